// File: rtl/pe_pkg.sv
// Shared widths, weight-control decode and vector slice helpers for the
// weight-stationary PE row and its MAC stages.
package pe_pkg;

  localparam int DEF_N         = 8;
  localparam int DEF_DATA_BW   = 8;
  localparam int DEF_WEIGHT_BW = 8;

  typedef enum logic [1:0] {
    WOP_NONE,
    WOP_LOAD,
    WOP_COMMIT
  } wop_e;

  // Wide enough that an n-term dot product of full-scale operands cannot overflow.
  function automatic int acc_bw(input int data_bw, input int weight_bw, input int n);
    return data_bw + weight_bw + $clog2(n);
  endfunction

  function automatic int data_lsb(input int k, input int data_bw);
    return k * data_bw;
  endfunction

  function automatic int weight_lsb(input int k, input int weight_bw);
    return k * weight_bw;
  endfunction

endpackage

// File: rtl/pe_mac_ws.sv
// One weight-stationary MAC stage: holds its active weight, adds its signed
// product into the incoming partial sum and forwards psum/valid/data downward.
module pe_mac_ws
  import pe_pkg::*;
#(
  parameter int DATA_BW   = DEF_DATA_BW,
  parameter int WEIGHT_BW = DEF_WEIGHT_BW,
  parameter int ACC_BW    = acc_bw(DEF_DATA_BW, DEF_WEIGHT_BW, DEF_N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BW-1:0]   din_i,
  input  logic                 valid_i,
  input  logic [ACC_BW-1:0]    psum_i,
  input  logic [WEIGHT_BW-1:0] w_i,
  input  logic                 w_en_i,
  output logic [ACC_BW-1:0]    psum_o,
  output logic                 valid_o,
  output logic [DATA_BW-1:0]   df_o
);

  localparam int PROD_BW = DATA_BW + WEIGHT_BW;

  logic [WEIGHT_BW-1:0]      w_q;
  logic [ACC_BW-1:0]         psum_q;
  logic [ACC_BW-1:0]         psum_d;
  logic                      valid_q;
  logic [DATA_BW-1:0]        df_q;
  logic signed [PROD_BW-1:0] prod;

  always_comb begin
    prod   = PROD_BW'($signed(din_i)) * PROD_BW'($signed(w_q));
    psum_d = psum_i + {{(ACC_BW-PROD_BW){prod[PROD_BW-1]}}, prod};
  end

  // psum only advances on valid samples so the row output holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      psum_q  <= '0;
      valid_q <= 1'b0;
      df_q    <= '0;
    end else begin
      if (w_en_i) w_q <= w_i;
      valid_q <= valid_i;
      df_q    <= valid_i ? din_i : '0;
      if (valid_i) psum_q <= psum_d;
    end
  end

  assign psum_o  = psum_q;
  assign valid_o = valid_q;
  assign df_o    = df_q;

endmodule

// File: rtl/pe_row_ws.sv
// Weight-stationary PE row: input skew, N chained MAC stages, and a
// double-buffered serial weight loader with a commit handshake.
module pe_row_ws
  import pe_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DATA_BW   = DEF_DATA_BW,
  parameter int WEIGHT_BW = DEF_WEIGHT_BW,
  parameter int ACC_BW    = acc_bw(DATA_BW, WEIGHT_BW, N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*DATA_BW-1:0]   din,
  input  logic                   din_valid,
  input  logic [ACC_BW-1:0]      psum_in,
  input  logic [WEIGHT_BW-1:0]   w_in,
  input  logic                   w_load,
  input  logic                   w_commit,
  output logic                   w_full,
  output logic                   w_ready,
  output logic                   w_err,
  output logic [N*DATA_BW-1:0]   df_out,
  output logic [ACC_BW-1:0]      result,
  output logic                   result_valid
);

  localparam int                CNT_BW   = $clog2(N + 1);
  localparam logic [CNT_BW-1:0] CNT_FULL = CNT_BW'(N);

  logic [N*WEIGHT_BW-1:0] shadow_q, shadow_d;
  logic [CNT_BW-1:0]      count_q, count_d;
  logic                   err_q, err_d;
  wop_e                   wop;
  logic [N-1:0]           valid_w;
  logic [ACC_BW-1:0]      psum_w [N];

  assign w_full  = (count_q == CNT_FULL);
  assign w_ready = w_full & ~(|valid_w) & ~din_valid;
  assign w_err   = err_q;

  // Commit has priority; a load in the same cycle as an accepted commit is dropped.
  always_comb begin
    wop      = WOP_NONE;
    err_d    = err_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    if (w_commit) begin
      if (w_ready) begin
        wop     = WOP_COMMIT;
        count_d = '0;
        if (w_load) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (w_load && (wop != WOP_COMMIT)) begin
      if (w_full) begin
        err_d = 1'b1;
      end else begin
        wop      = WOP_LOAD;
        shadow_d = {w_in, shadow_q[N*WEIGHT_BW-1:WEIGHT_BW]};
        count_d  = count_q + CNT_BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pe
    logic [DATA_BW-1:0] din_k;
    logic [ACC_BW-1:0]  psum_k;
    logic               valid_k;

    if (k == 0) begin : g_head
      assign din_k   = din[data_lsb(0, DATA_BW) +: DATA_BW];
      assign psum_k  = psum_in;
      assign valid_k = din_valid;
    end else begin : g_tail
      // Element k is delayed k cycles so it meets the partial sum at stage k.
      logic [DATA_BW-1:0] skew_q [k];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) skew_q[i] <= '0;
        end else begin
          skew_q[0] <= din[data_lsb(k, DATA_BW) +: DATA_BW];
          for (int i = 1; i < k; i++) skew_q[i] <= skew_q[i-1];
        end
      end

      assign din_k   = skew_q[k-1];
      assign psum_k  = psum_w[k-1];
      assign valid_k = valid_w[k-1];
    end

    pe_mac_ws #(
      .DATA_BW  (DATA_BW),
      .WEIGHT_BW(WEIGHT_BW),
      .ACC_BW   (ACC_BW)
    ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .din_i  (din_k),
      .valid_i(valid_k),
      .psum_i (psum_k),
      .w_i    (shadow_q[weight_lsb(k, WEIGHT_BW) +: WEIGHT_BW]),
      .w_en_i (wop == WOP_COMMIT),
      .psum_o (psum_w[k]),
      .valid_o(valid_w[k]),
      .df_o   (df_out[data_lsb(k, DATA_BW) +: DATA_BW])
    );
  end

  assign result       = psum_w[N-1];
  assign result_valid = valid_w[N-1];

endmodule

// File: tb/tb_pe_row_ws.sv
// Self-checking bench for pe_row_ws: directed scenarios plus a randomized
// stream scored against a plain-arithmetic dot-product model.
module tb_pe_row_ws;
  import pe_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int WB = 8;
  localparam int AW = acc_bw(DW, WB, N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] din;
  logic            din_valid;
  logic [AW-1:0]   psum_in;
  logic [WB-1:0]   w_in;
  logic            w_load;
  logic            w_commit;
  logic            w_full;
  logic            w_ready;
  logic            w_err;
  logic [N*DW-1:0] df_out;
  logic [AW-1:0]   result;
  logic            result_valid;

  int n_total = 0;
  int n_bad   = 0;
  int cycles  = 0;
  int mdl_w [N];

  typedef struct {
    int            due;
    logic [AW-1:0] val;
  } exp_t;

  always #5 clk = ~clk;

  pe_row_ws #(.N(N), .DATA_BW(DW), .WEIGHT_BW(WB), .ACC_BW(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .psum_in(psum_in),
    .w_in(w_in), .w_load(w_load), .w_commit(w_commit), .w_full(w_full),
    .w_ready(w_ready), .w_err(w_err), .df_out(df_out), .result(result),
    .result_valid(result_valid)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic idle_inputs();
    din       = '0;
    din_valid = 1'b0;
    psum_in   = '0;
    w_in      = '0;
    w_load    = 1'b0;
    w_commit  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) mdl_w[k] = 0;
  endtask

  task automatic load_shadow(input int w[N]);
    for (int k = 0; k < N; k++) begin
      w_load = 1'b1;
      w_in   = WB'(w[k]);
      step();
    end
    w_load = 1'b0;
  endtask

  task automatic commit_now(input int w[N]);
    w_commit = 1'b1;
    step();
    w_commit = 1'b0;
    mdl_w = w;
  endtask

  task automatic fire(input logic [N*DW-1:0] v, input logic [AW-1:0] ps);
    din       = v;
    psum_in   = ps;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din       = '0;
    psum_in   = '0;
  endtask

  function automatic logic [N*DW-1:0] fill_vec(input int x);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(x);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Reference: psum_in plus the signed dot product, wrapped to the result width.
  function automatic logic [AW-1:0] model_dot(input logic [N*DW-1:0] v, input int w[N],
                                              input logic [AW-1:0] ps);
    longint acc;
    acc = longint'(ps);
    for (int k = 0; k < N; k++) acc += longint'($signed(v[k*DW +: DW])) * longint'(w[k]);
    return AW'(acc);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_total++; if (result !== '0) begin n_bad++; $display("[TB] FAIL reset_result: got %0d want 0", result); end
    n_total++; if (result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", result_valid); end
    n_total++; if (w_full !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_w_full: got %b want 0", w_full); end
    n_total++; if (w_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_w_err: got %b want 0", w_err); end
    n_total++; if (w_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_w_ready: got %b want 0", w_ready); end
    n_total++; if (df_out !== '0) begin n_bad++; $display("[TB] FAIL reset_df_out: got %h want 0", df_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w [N];
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    logic early;
    for (int k = 0; k < N; k++) w[k] = k + 1;
    load_shadow(w);
    n_total++; if (w_full !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_w_full: got %b want 1", w_full); end
    n_total++; if (w_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_w_ready: got %b want 1", w_ready); end
    commit_now(w);
    n_total++; if (w_full !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_commit_clears_full: got %b want 0", w_full); end
    v = fill_vec(2);
    expv = model_dot(v, mdl_w, '0);
    fire(v, '0);
    early = 1'b0;
    for (int c = 1; c < N; c++) begin
      if (result_valid !== 1'b0) early = 1'b1;
      step();
    end
    n_total++; if (early) begin n_bad++; $display("[TB] FAIL basic_latency_early: result_valid=1 before %0d cycles, want 0", N); end
    n_total++; if (result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_latency: valid got %b want 1", result_valid); end
    n_total++; if (result !== expv) begin n_bad++; $display("[TB] FAIL basic_result: got %0d want %0d", $signed(result), $signed(expv)); end
    n_total++; if (w_err !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_w_err: got %b want 0", w_err); end
    step();
    n_total++; if (result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_valid_pulse: got %b want 0", result_valid); end
    n_total++; if (result !== expv) begin n_bad++; $display("[TB] FAIL basic_result_hold: got %0d want %0d", $signed(result), $signed(expv)); end
  endtask

  task automatic test_psum();
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    v = rand_vec();
    expv = model_dot(v, mdl_w, AW'(1000));
    fire(v, AW'(1000));
    for (int j = 1; j <= N; j++) begin
      n_total++;
      if (df_out[(j-1)*DW +: DW] !== v[(j-1)*DW +: DW]) begin
        n_bad++; $display("[TB] FAIL psum_df_elem%0d: got %h want %h", j - 1, df_out[(j-1)*DW +: DW], v[(j-1)*DW +: DW]);
      end
      if (j == 3) begin
        n_total++;
        if (df_out[3*DW +: DW] !== '0) begin n_bad++; $display("[TB] FAIL psum_df_elem3_early: got %h want 0", df_out[3*DW +: DW]); end
      end
      if (j < N) step();
    end
    n_total++; if (result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL psum_valid: got %b want 1", result_valid); end
    n_total++; if (result !== expv) begin n_bad++; $display("[TB] FAIL psum_result: got %0d want %0d", $signed(result), $signed(expv)); end
    step();
  endtask

  task automatic test_extremes();
    int w [N];
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    int wv [2];
    wv[0] = -128;
    wv[1] = 127;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < N; k++) w[k] = wv[t];
      load_shadow(w);
      commit_now(w);
      v = fill_vec(-128);
      expv = model_dot(v, mdl_w, '0);
      fire(v, '0);
      repeat (N - 1) step();
      n_total++; if (result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL extreme%0d_valid: got %b want 1", t, result_valid); end
      n_total++; if (result !== expv) begin n_bad++; $display("[TB] FAIL extreme%0d_result: got %0d want %0d", t, $signed(result), $signed(expv)); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int w [N];
    logic [AW-1:0] expv [N];
    for (int k = 0; k < N; k++) w[k] = 1;
    load_shadow(w);
    commit_now(w);
    for (int s = 0; s < N; s++) begin
      din       = fill_vec(s + 1);
      din_valid = 1'b1;
      expv[s]   = model_dot(fill_vec(s + 1), mdl_w, '0);
      step();
    end
    din_valid = 1'b0;
    din       = '0;
    for (int s = 0; s < N; s++) begin
      if (s > 0) step();
      n_total++; if (result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_valid%0d: got %b want 1", s, result_valid); end
      n_total++; if (result !== expv[s]) begin n_bad++; $display("[TB] FAIL b2b_result%0d: got %0d want %0d", s, $signed(result), $signed(expv[s])); end
    end
    step();
    n_total++; if (result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_drain: got %b want 0", result_valid); end
  endtask

  task automatic test_random();
    int w [N];
    exp_t sb [$];
    exp_t e;
    logic [N*DW-1:0] v;
    logic [AW-1:0] ps;
    for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 255)) - 128;
    load_shadow(w);
    commit_now(w);
    for (int i = 0; i < 200 + N; i++) begin
      if (i < 200 && $urandom_range(0, 3) != 0) begin
        v  = rand_vec();
        ps = AW'($urandom);
        din = v; psum_in = ps; din_valid = 1'b1;
        e.due = cycles + N;
        e.val = model_dot(v, mdl_w, ps);
        sb.push_back(e);
      end else begin
        din_valid = 1'b0; din = '0; psum_in = '0;
      end
      step();
      if (sb.size() > 0 && sb[0].due == cycles) begin
        n_total++; if (result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL rand_valid@%0d: got %b want 1", cycles, result_valid); end
        n_total++; if (result !== sb[0].val) begin n_bad++; $display("[TB] FAIL rand_result@%0d: got %0d want %0d", cycles, $signed(result), $signed(sb[0].val)); end
        void'(sb.pop_front());
      end else begin
        n_total++; if (result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rand_idle@%0d: got %b want 0", cycles, result_valid); end
      end
    end
    n_total++; if (sb.size() != 0) begin n_bad++; $display("[TB] FAIL rand_leftover: got %0d pending want 0", sb.size()); end
    idle_inputs();
  endtask

  task automatic test_load_overflow();
    int w [N];
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    do_reset();
    for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 255)) - 128;
    load_shadow(w);
    n_total++; if (w_err !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_err_before: got %b want 0", w_err); end
    w_load = 1'b1; w_in = WB'(99);
    step();
    w_load = 1'b0;
    n_total++; if (w_err !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_err: got %b want 1", w_err); end
    n_total++; if (w_full !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_full: got %b want 1", w_full); end
    commit_now(w);
    n_total++; if (w_full !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_commit: got %b want 0", w_full); end
    v = rand_vec();
    expv = model_dot(v, mdl_w, '0);
    fire(v, '0);
    repeat (N - 1) step();
    n_total++; if (result !== expv || result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_shadow_kept: got %0d (valid %b) want %0d", $signed(result), result_valid, $signed(expv)); end
    step();
  endtask

  task automatic test_commit_load_same();
    int w [N];
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    do_reset();
    for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 255)) - 128;
    load_shadow(w);
    w_commit = 1'b1; w_load = 1'b1; w_in = WB'(55);
    n_total++; if (w_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL same_ready: got %b want 1", w_ready); end
    step();
    w_commit = 1'b0; w_load = 1'b0;
    mdl_w = w;
    n_total++; if (w_err !== 1'b1) begin n_bad++; $display("[TB] FAIL same_err: got %b want 1", w_err); end
    n_total++; if (w_full !== 1'b0) begin n_bad++; $display("[TB] FAIL same_full: got %b want 0", w_full); end
    for (int k = 0; k < N - 1; k++) begin
      w_load = 1'b1; w_in = WB'($urandom);
      step();
    end
    w_load = 1'b0;
    n_total++; if (w_full !== 1'b0) begin n_bad++; $display("[TB] FAIL same_load_dropped: got full %b want 0", w_full); end
    w_load = 1'b1; w_in = WB'($urandom);
    step();
    w_load = 1'b0;
    n_total++; if (w_full !== 1'b1) begin n_bad++; $display("[TB] FAIL same_refill: got %b want 1", w_full); end
    v = rand_vec();
    expv = model_dot(v, mdl_w, '0);
    fire(v, '0);
    repeat (N - 1) step();
    n_total++; if (result !== expv || result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL same_active: got %0d (valid %b) want %0d", $signed(result), result_valid, $signed(expv)); end
    step();
  endtask

  task automatic test_commit_inflight();
    int wa [N];
    int wb [N];
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    do_reset();
    for (int k = 0; k < N; k++) begin wa[k] = 1; wb[k] = 3; end
    load_shadow(wa);
    commit_now(wa);
    n_total++; if (w_err !== 1'b0) begin n_bad++; $display("[TB] FAIL infl_err_before: got %b want 0", w_err); end
    load_shadow(wb);
    v = fill_vec(1);
    expv = model_dot(v, mdl_w, '0);
    fire(v, '0);
    w_commit = 1'b1;
    n_total++; if (w_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL infl_ready: got %b want 0", w_ready); end
    step();
    w_commit = 1'b0;
    n_total++; if (w_err !== 1'b1) begin n_bad++; $display("[TB] FAIL infl_err: got %b want 1", w_err); end
    n_total++; if (w_full !== 1'b1) begin n_bad++; $display("[TB] FAIL infl_full_kept: got %b want 1", w_full); end
    repeat (N - 2) step();
    n_total++; if (result !== expv || result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL infl_old_weights: got %0d (valid %b) want %0d", $signed(result), result_valid, $signed(expv)); end
    step();
    n_total++; if (w_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL infl_drained_ready: got %b want 1", w_ready); end
    commit_now(wb);
    n_total++; if (w_full !== 1'b0) begin n_bad++; $display("[TB] FAIL infl_commit_ok: got %b want 0", w_full); end
    expv = model_dot(v, mdl_w, '0);
    fire(v, '0);
    repeat (N - 1) step();
    n_total++; if (result !== expv || result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL infl_new_weights: got %0d (valid %b) want %0d", $signed(result), result_valid, $signed(expv)); end
    step();
  endtask

  task automatic test_reset_midflight();
    logic [N*DW-1:0] v;
    logic [AW-1:0] expv;
    logic seen;
    fire(rand_vec(), '0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) mdl_w[k] = 0;
    n_total++; if (result !== '0) begin n_bad++; $display("[TB] FAIL mid_result: got %0d want 0", result); end
    n_total++; if (result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_valid: got %b want 0", result_valid); end
    n_total++; if (df_out !== '0) begin n_bad++; $display("[TB] FAIL mid_df: got %h want 0", df_out); end
    n_total++; if (w_err !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_err: got %b want 0", w_err); end
    seen = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      step();
      if (result_valid !== 1'b0 || result !== '0) seen = 1'b1;
    end
    n_total++; if (seen) begin n_bad++; $display("[TB] FAIL mid_discarded: got a result after reset, want none"); end
    v = rand_vec();
    expv = model_dot(v, mdl_w, '0);
    fire(v, '0);
    repeat (N - 1) step();
    n_total++; if (result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_post_valid: got %b want 1", result_valid); end
    n_total++; if (result !== expv) begin n_bad++; $display("[TB] FAIL mid_post_result: got %0d want %0d", $signed(result), $signed(expv)); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < N; k++) mdl_w[k] = 0;
    test_reset();
    test_basic();
    test_psum();
    test_extremes();
    test_back_to_back();
    test_random();
    test_load_overflow();
    test_commit_load_same();
    test_commit_inflight();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
